led_scan_ctrl: RTL and testbench

Scan controller for the LED matrix display. It generates the column-multiplex sequence from the system clock and inserts a blanking gap between columns to suppress ghosting. Each enabled column is driven with row data from a double-buffered frame register. Game logic hands over complete frames through a valid/ready handshake; new frames take effect only at a frame boundary, so the display never shows a torn frame.

---
 rtl/led_scan_ctrl_if.sv | 13 +
 rtl/led_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_led_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_scan_ctrl_if.sv
// Frame hand-over channel from the game logic to the LED scan controller.
// A frame moves across on any cycle where frameValid && frameReady.
interface led_scan_ctrl_if #(
    parameter int COLS = 4,
    parameter int ROWS = 8
);
    logic [COLS*ROWS-1:0] frameData;
    logic                 frameValid;
    logic                 frameReady;

    modport master (output frameData, output frameValid, input frameReady);
    modport slave  (input frameData, input frameValid, output frameReady);
endinterface

// File: rtl/led_scan_ctrl.sv
// LED matrix column scanner: a blanking gap precedes each driven column, and the
// row data comes from a double-buffered frame that is swapped only at frame boundaries.
module led_scan_ctrl #(
    parameter int COLS  = 4,
    parameter int ROWS  = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            enable,
    led_scan_ctrl_if.slave  frame_if,
    output logic [COLS-1:0] colEn,
    output logic [ROWS-1:0] rowEn,
    output logic            frameStart
);
    localparam int FRAME_W = COLS * ROWS;
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int COL_W   = $clog2(COLS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t             r_state, w_stateNext;
    logic [COL_W-1:0]   r_col, w_colNext;
    logic [CNT_W-1:0]   r_cnt, w_cntNext;
    // Low after a disabled cycle: the next enabled edge restarts the scan and pulses frameStart.
    logic               r_run;
    logic [FRAME_W-1:0] r_active, r_pending;
    logic               r_pendingFull, r_frameReady;
    logic [COLS-1:0]    r_colEn, w_colEnNext;
    logic [ROWS-1:0]    r_rowEn, w_rowEnNext;
    logic               r_frameStart, w_frameStartNext;
    logic               w_boundary, w_accept, w_swap, w_pendFullNext;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_BLANK;
            r_col        <= '0;
            r_cnt        <= '0;
            r_run        <= 1'b1;
            r_colEn      <= '0;
            r_rowEn      <= '0;
            r_frameStart <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_col        <= w_colNext;
            r_cnt        <= w_cntNext;
            r_run        <= enable;
            r_colEn      <= w_colEnNext;
            r_rowEn      <= w_rowEnNext;
            r_frameStart <= w_frameStartNext;
        end
    end

    always_comb begin
        w_stateNext      = r_state;
        w_colNext        = r_col;
        w_cntNext        = r_cnt + 1'b1;
        w_boundary       = 1'b0;
        w_frameStartNext = 1'b0;
        if (!enable) begin
            w_stateNext = S_BLANK;
            w_colNext   = '0;
            w_cntNext   = '0;
        end else if (!r_run) begin
            w_stateNext      = S_BLANK;
            w_colNext        = '0;
            w_cntNext        = '0;
            w_frameStartNext = 1'b1;
        end else begin
            case (r_state)
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_stateNext = S_DRIVE;
                        w_cntNext   = '0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_stateNext = S_BLANK;
                        w_cntNext   = '0;
                        if (r_col == COL_LAST) begin
                            w_colNext        = '0;
                            w_boundary       = 1'b1;
                            w_frameStartNext = 1'b1;
                        end else begin
                            w_colNext = r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        w_colEnNext = '0;
        w_rowEnNext = '0;
        if (w_stateNext == S_DRIVE) begin
            w_colEnNext[w_colNext] = 1'b1;
            w_rowEnNext            = r_active[int'(w_colNext) * ROWS +: ROWS];
        end
    end

    // Accept needs an empty pending buffer and swap needs a full one, so they never coincide.
    assign w_accept       = frame_if.frameValid && r_frameReady;
    assign w_swap         = w_boundary && r_pendingFull;
    assign w_pendFullNext = (r_pendingFull && !w_swap) || w_accept;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_active      <= '0;
            r_pending     <= '0;
            r_pendingFull <= 1'b0;
            r_frameReady  <= 1'b1;
        end else begin
            if (w_accept) r_pending <= frame_if.frameData;
            if (w_swap)   r_active  <= r_pending;
            r_pendingFull <= w_pendFullNext;
            r_frameReady  <= !w_pendFullNext;
        end
    end

    assign colEn             = r_colEn;
    assign rowEn             = r_rowEn;
    assign frameStart        = r_frameStart;
    assign frame_if.frameReady = r_frameReady;
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl: accepted frames are queued by a cycle
// model of the scan timing and popped when the model reaches a frame boundary.
module tb_led_scan_ctrl;
    localparam int COLS   = 4;
    localparam int ROWS   = 8;
    localparam int DWELL  = 5;
    localparam int BLANK  = 2;
    localparam int PERIOD = BLANK + DWELL;
    localparam int FRAME  = COLS * PERIOD;

    logic            clk = 1'b0;
    logic            resetN;
    logic            enable;
    logic [COLS-1:0] colEn;
    logic [ROWS-1:0] rowEn;
    logic            frameStart;

    led_scan_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) frame_if ();

    led_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .enable     (enable),
        .frame_if   (frame_if),
        .colEn      (colEn),
        .rowEn      (rowEn),
        .frameStart (frameStart)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int                   m_pos;
    bit                   m_fs;
    bit                   m_run;
    bit                   m_acc;
    logic [COLS*ROWS-1:0] m_frame;
    logic [COLS*ROWS-1:0] m_q[$];

    function automatic logic [COLS-1:0] exp_col();
        logic [COLS-1:0] v;
        v = '0;
        if (m_pos % PERIOD >= BLANK) v[m_pos / PERIOD] = 1'b1;
        return v;
    endfunction

    function automatic logic [ROWS-1:0] exp_row();
        int c;
        c = m_pos / PERIOD;
        if (m_pos % PERIOD >= BLANK) return m_frame[c*ROWS +: ROWS];
        return '0;
    endfunction

    task automatic model_reset();
        m_pos   = 0;
        m_fs    = 1'b0;
        m_run   = 1'b1;
        m_acc   = 1'b0;
        m_frame = '0;
        m_q.delete();
    endtask

    task automatic step();
        bit boundary;
        @(posedge clk);
        boundary = enable && m_run && (m_pos == FRAME - 1);
        m_acc    = frame_if.frameValid && (m_q.size() == 0);
        if (!enable) begin
            m_pos = 0; m_run = 1'b0; m_fs = 1'b0;
        end else if (!m_run) begin
            m_pos = 0; m_run = 1'b1; m_fs = 1'b1;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            m_fs  = (m_pos == 0);
        end
        if (boundary && m_q.size() > 0) m_frame = m_q.pop_front();
        if (m_acc) m_q.push_back(frame_if.frameData);
        @(negedge clk);
    endtask

    task automatic advance_to(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 2 * FRAME + 4) begin
            step();
            n++;
        end
        if (m_pos != p) begin
            checks++; errors++;
            $display("FAIL advance_to pos got=%0d exp=%0d", m_pos, p);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (colEn !== '0) begin errors++; $display("FAIL reset colEn got=%b exp=0", colEn); end
        checks++; if (rowEn !== '0) begin errors++; $display("FAIL reset rowEn got=%h exp=0", rowEn); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL reset frameStart got=%b exp=0", frameStart); end
        checks++; if (frame_if.frameReady !== 1'b1) begin errors++; $display("FAIL reset frameReady got=%b exp=1", frame_if.frameReady); end
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        int first_fs;
        int pulses;
        first_fs = -1;
        pulses   = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            checks++; if (colEn !== exp_col()) begin errors++; $display("FAIL scan colEn cyc=%0d got=%b exp=%b", i, colEn, exp_col()); end
            checks++; if (rowEn !== '0) begin errors++; $display("FAIL scan rowEn cyc=%0d got=%h exp=0", i, rowEn); end
            checks++; if (frameStart !== m_fs) begin errors++; $display("FAIL scan frameStart cyc=%0d got=%b exp=%b", i, frameStart, m_fs); end
            if (frameStart === 1'b1) begin
                pulses++;
                if (first_fs < 0) first_fs = i;
            end
            if (i == 2 || i == 30) begin
                checks++; if (colEn !== 4'b0001) begin errors++; $display("FAIL scan col0_start cyc=%0d got=%b exp=0001", i, colEn); end
            end
        end
        checks++; if (first_fs != 28) begin errors++; $display("FAIL scan first_frameStart got=%0d exp=28", first_fs); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL scan frameStart_count got=%0d exp=2", pulses); end
    endtask

    task automatic test_frame_load();
        advance_to(3);
        frame_if.frameData  = 32'h44332211;
        frame_if.frameValid = 1'b1;
        step();
        frame_if.frameValid = 1'b0;
        checks++; if (frame_if.frameReady !== 1'b0) begin errors++; $display("FAIL load ready_drop got=%b exp=0", frame_if.frameReady); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++; if (colEn !== exp_col()) begin errors++; $display("FAIL load colEn i=%0d got=%b exp=%b", i, colEn, exp_col()); end
            checks++; if (rowEn !== exp_row()) begin errors++; $display("FAIL load rowEn i=%0d got=%h exp=%h", i, rowEn, exp_row()); end
            checks++; if (frameStart !== m_fs) begin errors++; $display("FAIL load frameStart i=%0d got=%b exp=%b", i, frameStart, m_fs); end
            checks++; if (frame_if.frameReady !== (m_q.size() == 0)) begin errors++; $display("FAIL load frameReady i=%0d got=%b exp=%b", i, frame_if.frameReady, m_q.size() == 0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fa;
        logic [31:0] fb;
        fa = 32'hA4A3A2A1;
        fb = 32'hB4B3B2B1;
        advance_to(5);
        frame_if.frameData  = fa;
        frame_if.frameValid = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (m_acc) begin
                if (frame_if.frameData === fa) frame_if.frameData = fb;
                else frame_if.frameValid = 1'b0;
            end
            checks++; if (colEn !== exp_col()) begin errors++; $display("FAIL b2b colEn i=%0d got=%b exp=%b", i, colEn, exp_col()); end
            checks++; if (rowEn !== exp_row()) begin errors++; $display("FAIL b2b rowEn i=%0d got=%h exp=%h", i, rowEn, exp_row()); end
            checks++; if (frameStart !== m_fs) begin errors++; $display("FAIL b2b frameStart i=%0d got=%b exp=%b", i, frameStart, m_fs); end
            checks++; if (frame_if.frameReady !== (m_q.size() == 0)) begin errors++; $display("FAIL b2b frameReady i=%0d got=%b exp=%b", i, frame_if.frameReady, m_q.size() == 0); end
        end
        frame_if.frameValid = 1'b0;
    endtask

    task automatic test_boundary_handshake();
        advance_to(FRAME - 1);
        frame_if.frameData  = 32'hC4C3C2C1;
        frame_if.frameValid = 1'b1;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step();
            frame_if.frameValid = 1'b0;
            checks++; if (colEn !== exp_col()) begin errors++; $display("FAIL bnd colEn i=%0d got=%b exp=%b", i, colEn, exp_col()); end
            checks++; if (rowEn !== exp_row()) begin errors++; $display("FAIL bnd rowEn i=%0d got=%h exp=%h", i, rowEn, exp_row()); end
            checks++; if (frameStart !== m_fs) begin errors++; $display("FAIL bnd frameStart i=%0d got=%b exp=%b", i, frameStart, m_fs); end
            checks++; if (frame_if.frameReady !== (m_q.size() == 0)) begin errors++; $display("FAIL bnd frameReady i=%0d got=%b exp=%b", i, frame_if.frameReady, m_q.size() == 0); end
        end
    endtask

    task automatic test_enable_toggle();
        advance_to(1);
        frame_if.frameData  = 32'hD4D3D2D1;
        frame_if.frameValid = 1'b1;
        step();
        frame_if.frameValid = 1'b0;
        advance_to(2 * PERIOD + BLANK + 1);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (colEn !== '0) begin errors++; $display("FAIL en_off colEn i=%0d got=%b exp=0", i, colEn); end
            checks++; if (rowEn !== '0) begin errors++; $display("FAIL en_off rowEn i=%0d got=%h exp=0", i, rowEn); end
            checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL en_off frameStart i=%0d got=%b exp=0", i, frameStart); end
            checks++; if (frame_if.frameReady !== 1'b0) begin errors++; $display("FAIL en_off frameReady i=%0d got=%b exp=0", i, frame_if.frameReady); end
        end
        enable = 1'b1;
        for (int i = 0; i < 70; i++) begin
            step();
            if (i == 0) begin
                checks++; if (frameStart !== 1'b1) begin errors++; $display("FAIL en_on first_frameStart got=%b exp=1", frameStart); end
            end
            if (i == 2) begin
                checks++; if (colEn !== 4'b0001) begin errors++; $display("FAIL en_on first_col got=%b exp=0001", colEn); end
            end
            checks++; if (colEn !== exp_col()) begin errors++; $display("FAIL en_on colEn i=%0d got=%b exp=%b", i, colEn, exp_col()); end
            checks++; if (rowEn !== exp_row()) begin errors++; $display("FAIL en_on rowEn i=%0d got=%h exp=%h", i, rowEn, exp_row()); end
            checks++; if (frameStart !== m_fs) begin errors++; $display("FAIL en_on frameStart i=%0d got=%b exp=%b", i, frameStart, m_fs); end
            checks++; if (frame_if.frameReady !== (m_q.size() == 0)) begin errors++; $display("FAIL en_on frameReady i=%0d got=%b exp=%b", i, frame_if.frameReady, m_q.size() == 0); end
        end
    endtask

    task automatic test_async_reset();
        advance_to(1);
        frame_if.frameData  = 32'hE4E3E2E1;
        frame_if.frameValid = 1'b1;
        step();
        frame_if.frameValid = 1'b0;
        advance_to(PERIOD + BLANK + 1);
        checks++; if (rowEn !== 8'hD2) begin errors++; $display("FAIL arst pre_rowEn got=%h exp=d2", rowEn); end
        #2 resetN = 1'b0;
        #1;
        checks++; if (colEn !== '0) begin errors++; $display("FAIL arst colEn got=%b exp=0", colEn); end
        checks++; if (rowEn !== '0) begin errors++; $display("FAIL arst rowEn got=%h exp=0", rowEn); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("FAIL arst frameStart got=%b exp=0", frameStart); end
        checks++; if (frame_if.frameReady !== 1'b1) begin errors++; $display("FAIL arst frameReady got=%b exp=1", frame_if.frameReady); end
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step();
            checks++; if (colEn !== exp_col()) begin errors++; $display("FAIL arst_post colEn i=%0d got=%b exp=%b", i, colEn, exp_col()); end
            checks++; if (rowEn !== '0) begin errors++; $display("FAIL arst_post rowEn i=%0d got=%h exp=0", i, rowEn); end
            checks++; if (frameStart !== m_fs) begin errors++; $display("FAIL arst_post frameStart i=%0d got=%b exp=%b", i, frameStart, m_fs); end
            checks++; if (frame_if.frameReady !== 1'b1) begin errors++; $display("FAIL arst_post frameReady i=%0d got=%b exp=1", i, frame_if.frameReady); end
        end
    endtask

    initial begin
        resetN              = 1'b0;
        enable              = 1'b1;
        frame_if.frameValid = 1'b0;
        frame_if.frameData  = '0;
        model_reset();
        test_reset();
        test_scan();
        test_frame_load();
        test_back_to_back();
        test_boundary_handshake();
        test_enable_toggle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
